// File: rtl/tx_video_pkg.sv
// Shared definitions for the transmit video timing path: state encoding,
// default 640x480 timing constants and counter width.
package tx_video_pkg;

  localparam int unsigned CNT_W            = 12;
  localparam int unsigned CNT_MAX          = 4096;

  localparam int unsigned DEF_DIV          = 5;
  localparam int unsigned DEF_H_ACTIVE     = 640;
  localparam int unsigned DEF_H_TOTAL      = 800;
  localparam int unsigned DEF_V_ACTIVE     = 480;
  localparam int unsigned DEF_V_TOTAL      = 525;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_e;

  // Prescaler width; kept at least 1 bit so DIV=2 still gets a real register.
  function automatic int unsigned div_cnt_w(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tx_pix_div.sv
// Free-running clk/DIV prescaler: PixelEn at count 0 (sample point),
// pixel edge at count DIV-1 (where pixel-rate registers update).
module tx_pix_div
  import tx_video_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rstn,
  output logic pix_en_o,
  output logic pix_edge_o
);

  localparam int unsigned    W    = div_cnt_w(DIV);
  localparam logic [W-1:0]   LAST = W'(DIV - 1);

  logic [W-1:0] cnt_div_q;
  logic [W-1:0] cnt_div_d;

  always_comb begin
    cnt_div_d = (cnt_div_q == LAST) ? '0 : cnt_div_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_div_q <= '0;
    end else begin
      cnt_div_q <= cnt_div_d;
    end
  end

  assign pix_en_o   = (cnt_div_q == '0);
  assign pix_edge_o = (cnt_div_q == LAST);

endmodule

// File: rtl/tx_sync_gen.sv
// Transmit-side video timing generator: H/V counters, IDLE/RUN/DRAIN control
// and registered framing outputs, all advanced once per pixel edge.
module tx_sync_gen
  import tx_video_pkg::*;
#(
  parameter int unsigned DIV      = DEF_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_TOTAL  = DEF_V_TOTAL
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  output logic             PixelEn,
  output logic             HVsync,
  output logic             HMemRead,
  output logic             pVDE,
  output logic [CNT_W-1:0] HCnt,
  output logic [CNT_W-1:0] VCnt,
  output logic             FrameStart
);

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_chk_width
    $error("tx_sync_gen: H_TOTAL/V_TOTAL exceed 12-bit counter range");
  end
  if (H_ACTIVE < 1 || H_ACTIVE >= H_TOTAL || V_ACTIVE < 1 || V_ACTIVE >= V_TOTAL) begin : g_chk_act
    $error("tx_sync_gen: active region must be non-empty and smaller than total");
  end
  if (DIV < 2) begin : g_chk_div
    $error("tx_sync_gen: DIV must be at least 2");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);

  logic             pix_edge;
  tx_state_e        state_q;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             hvsync_q;
  logic             hmemread_q;
  logic             pvde_q;
  logic             framestart_q;
  logic             line_end;
  logic             frame_end;

  tx_pix_div #(
    .DIV(DIV)
  ) u_pix_div (
    .clk        (clk),
    .rstn       (rstn),
    .pix_en_o   (PixelEn),
    .pix_edge_o (pix_edge)
  );

  always_comb begin
    line_end  = (hcnt_q == H_LAST);
    frame_end = line_end && (vcnt_q == V_LAST);
    hcnt_d    = line_end ? '0 : hcnt_q + 1'b1;
    vcnt_d    = vcnt_q;
    if (line_end) begin
      vcnt_d = frame_end ? '0 : vcnt_q + 1'b1;
    end
  end

  // FrameStart is cleared on every clk so it lasts only the first clk of (0,0).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      hvsync_q     <= 1'b0;
      hmemread_q   <= 1'b0;
      pvde_q       <= 1'b0;
      framestart_q <= 1'b0;
    end else begin
      framestart_q <= 1'b0;
      if (pix_edge) begin
        pvde_q <= hmemread_q;
        case (state_q)
          ST_IDLE: begin
            if (run) begin
              state_q      <= ST_RUN;
              hcnt_q       <= '0;
              vcnt_q       <= '0;
              hvsync_q     <= 1'b1;
              hmemread_q   <= 1'b1;
              framestart_q <= 1'b1;
            end
          end
          ST_RUN, ST_DRAIN: begin
            // Only a drain that is still stopped at the frame wrap parks in IDLE;
            // otherwise RUN and DRAIN share the same counting path.
            if (state_q == ST_DRAIN && !run && frame_end) begin
              state_q    <= ST_IDLE;
              hcnt_q     <= '0;
              vcnt_q     <= '0;
              hvsync_q   <= 1'b0;
              hmemread_q <= 1'b0;
            end else begin
              state_q      <= run ? ST_RUN : ST_DRAIN;
              hcnt_q       <= hcnt_d;
              vcnt_q       <= vcnt_d;
              hvsync_q     <= (vcnt_d < V_ACT);
              hmemread_q   <= (vcnt_d < V_ACT) && (hcnt_d < H_ACT);
              framestart_q <= frame_end;
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            hvsync_q   <= 1'b0;
            hmemread_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign HCnt       = hcnt_q;
  assign VCnt       = vcnt_q;
  assign HVsync     = hvsync_q;
  assign HMemRead   = hmemread_q;
  assign pVDE       = pvde_q;
  assign FrameStart = framestart_q;

endmodule
